// File: rtl/io_in_pkg.sv
// Shared address map and select decoding for the I/O input-port bank.
// Used by the bank top and its testbenches.
package io_in_pkg;

   localparam logic [5:0] IO_IN_PORT_BASE_SEL = 6'b110000;
   localparam logic [5:0] IO_IN_STATUS_SEL    = 6'b111111;
   localparam int         IO_IN_MAX_PORTS     = 8;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_PORT,
      RD_STATUS
   } rd_kind_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] idx;
   } port_sel_t;

   function automatic port_sel_t sel_to_port(
      input logic [5:0]  sel,
      input int unsigned num_ports
   );
      port_sel_t r;
      logic      in_window;
      in_window = (sel[5:3] == IO_IN_PORT_BASE_SEL[5:3]);
      r.idx     = sel[2:0];
      r.valid   = in_window && (32'(sel[2:0]) < num_ports);
      return r;
   endfunction

   function automatic rd_kind_t sel_to_kind(
      input logic [5:0]  sel,
      input int unsigned num_ports
   );
      port_sel_t p;
      rd_kind_t  k;
      p = sel_to_port(sel, num_ports);
      k = RD_NONE;
      if (sel == IO_IN_STATUS_SEL)
         k = RD_STATUS;
      else if (p.valid)
         k = RD_PORT;
      return k;
   endfunction

endpackage

// File: rtl/io_in_channel.sv
// One input channel: two-flop synchroniser, stability debouncer
// and a sticky change flag with set-over-clear priority.
module io_in_channel
   import io_in_pkg::*;
#(
   parameter int PORT_W     = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic              io_clk,
   input  logic              reset,
   input  logic [PORT_W-1:0] pin,
   input  logic              clr,
   output logic [PORT_W-1:0] value,
   output logic              flag
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [PORT_W-1:0] ff1;
   logic [PORT_W-1:0] sync;
   logic [PORT_W-1:0] cand;
   logic [PORT_W-1:0] latched;
   logic [CNT_W-1:0]  cnt;
   logic              flag_q;

   logic              moved;
   logic              pending;
   logic              fire;

   assign moved   = (sync != cand);
   assign pending = !moved && (cand != latched);
   assign fire    = pending && (cnt == CNT_LAST);

   always_ff @(posedge io_clk or posedge reset) begin
      if (reset) begin
         ff1     <= '0;
         sync    <= '0;
         cand    <= '0;
         latched <= '0;
         cnt     <= '0;
         flag_q  <= 1'b0;
      end else begin
         ff1  <= pin;
         sync <= ff1;
         // any wander at the sync stage restarts the window
         if (moved) begin
            cand <= sync;
            cnt  <= '0;
         end else if (pending) begin
            if (fire) begin
               latched <= cand;
               cnt     <= '0;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end else begin
            cnt <= '0;
         end
         if (fire)
            flag_q <= 1'b1;
         else if (clr)
            flag_q <= 1'b0;
      end
   end

   assign value = latched;
   assign flag  = flag_q;

endmodule

// File: rtl/io_input_bank.sv
// Memory-mapped input-port bank: NUM_PORTS debounced channels,
// read-to-clear status register and level interrupt.
module io_input_bank
   import io_in_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int PORT_W     = 8,
   parameter int DEB_CYCLES = 4
) (
   input  logic                        io_clk,
   input  logic                        reset,
   input  logic [31:0]                 addr,
   input  logic                        io_rd,
   input  logic [NUM_PORTS*PORT_W-1:0] in_port,
   output logic [31:0]                 io_read_data,
   output logic                        io_irq
);

   logic [5:0]                         sel;
   logic                               clr;
   logic [NUM_PORTS-1:0]               flags;
   logic [NUM_PORTS-1:0][PORT_W-1:0]   values;
   port_sel_t                          psel;
   rd_kind_t                           kind;
   logic                               unused_addr;

   assign sel         = addr[7:2];
   assign unused_addr = ^{addr[31:8], addr[1:0]};
   assign clr         = io_rd && (sel == IO_IN_STATUS_SEL);

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
      io_in_channel #(
         .PORT_W     (PORT_W),
         .DEB_CYCLES (DEB_CYCLES)
      ) u_ch (
         .io_clk (io_clk),
         .reset  (reset),
         .pin    (in_port[g*PORT_W +: PORT_W]),
         .clr    (clr),
         .value  (values[g]),
         .flag   (flags[g])
      );
   end

   always_comb begin
      psel         = sel_to_port(sel, NUM_PORTS);
      kind         = sel_to_kind(sel, NUM_PORTS);
      io_read_data = '0;
      unique case (kind)
         RD_STATUS: io_read_data[NUM_PORTS-1:0] = flags;
         RD_PORT: begin
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (psel.idx == 3'(i))
                  io_read_data[PORT_W-1:0] = values[i];
            end
         end
         default: io_read_data = '0;
      endcase
   end

   // driven only by flag registers, so addr activity cannot glitch it
   assign io_irq = |flags;

endmodule

// File: tb/tb_io_input_bank.sv
// Scoreboard bench for io_input_bank: default 4x8 bank plus a
// single 12-bit port instance for zero-extension.
module tb_io_input_bank;

   logic        io_clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        io_rd;
   logic [31:0] in_port;
   logic [11:0] w_in;
   logic [31:0] rd_data;
   logic [31:0] w_data;
   logic        irq;
   logic        w_irq;
   logic        chk;

   typedef struct {
      bit          wide;
      logic [31:0] data;
      logic        irq;
      string       name;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;

   always #5 io_clk = ~io_clk;

   io_input_bank #(
      .NUM_PORTS (4),
      .PORT_W    (8),
      .DEB_CYCLES(4)
   ) dut (
      .io_clk       (io_clk),
      .reset        (reset),
      .addr         (addr),
      .io_rd        (io_rd),
      .in_port      (in_port),
      .io_read_data (rd_data),
      .io_irq       (irq)
   );

   io_input_bank #(
      .NUM_PORTS (1),
      .PORT_W    (12),
      .DEB_CYCLES(4)
   ) u_wide (
      .io_clk       (io_clk),
      .reset        (reset),
      .addr         (addr),
      .io_rd        (io_rd),
      .in_port      (w_in),
      .io_read_data (w_data),
      .io_irq       (w_irq)
   );

   always @(negedge io_clk) begin
      if (chk) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: output presented, no expectation");
         end else begin
            e = q.pop_front();
            checks++;
            if ((e.wide ? w_data : rd_data) !== e.data) begin
               errors++;
               $display("FAIL %s data: got %h expected %h", e.name,
                        e.wide ? w_data : rd_data, e.data);
            end
            checks++;
            if ((e.wide ? w_irq : irq) !== e.irq) begin
               errors++;
               $display("FAIL %s irq: got %b expected %b", e.name,
                        e.wide ? w_irq : irq, e.irq);
            end
         end
      end
   end

   task automatic step();
      @(posedge io_clk);
      #1;
      chk   = 1'b0;
      io_rd = 1'b0;
   endtask

   task automatic probe(input bit wide, input logic [31:0] a,
                        input logic rd, input logic [31:0] d,
                        input logic ir, input string nm);
      exp_t x;
      x.wide = wide;
      x.data = d;
      x.irq  = ir;
      x.name = nm;
      q.push_back(x);
      addr  = a;
      io_rd = rd;
      chk   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      addr    = '0;
      io_rd   = 1'b0;
      in_port = '0;
      w_in    = '0;
      chk     = 1'b0;

      step(); probe(0, 32'hC0, 0, 32'h0, 0, "rst_port0");
      step(); probe(0, 32'hFC, 0, 32'h0, 0, "rst_status");
      step(); probe(0, 32'hD0, 0, 32'h0, 0, "rst_unmapped");
      step(); probe(1, 32'hC0, 0, 32'h0, 0, "rst_wide");
      step();
      reset = 1'b0;

      // reset mid-count on port0
      in_port[7:0] = 8'hA5;
      for (int k = 0; k < 4; k++) begin
         step(); probe(0, 32'hC0, 0, 32'h0, 0, "mid_pre");
      end
      reset = 1'b1;
      step(); probe(0, 32'hC0, 0, 32'h0, 0, "mid_in_rst");
      step(); probe(0, 32'hFC, 0, 32'h0, 0, "mid_in_rst_st");
      reset = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         probe(0, 32'hC0, 0, (k == 6) ? 32'hA5 : 32'h0,
               k == 6, "post_rst_lat");
      end
      step(); probe(0, 32'hFC, 1, 32'h1, 1, "clr0_read");
      step(); probe(0, 32'hFC, 0, 32'h0, 0, "clr0_after");

      // stable change on port1
      in_port[15:8] = 8'h3C;
      for (int k = 0; k < 7; k++) begin
         step();
         probe(0, 32'hC4, 0, (k == 6) ? 32'h3C : 32'h0,
               k == 6, "p1_lat");
      end
      step(); probe(0, 32'hFC, 0, 32'h2, 1, "p1_status");
      step(); probe(0, 32'hC4, 1, 32'h3C, 1, "p1_rd_noclr");
      step(); probe(0, 32'h1C4, 0, 32'h3C, 1, "p1_alias");
      step(); probe(0, 32'hFC, 1, 32'h2, 1, "p1_clr_read");
      step(); probe(0, 32'hFC, 0, 32'h0, 0, "p1_clr_after");
      step(); probe(0, 32'hC4, 0, 32'h3C, 0, "p1_keep");

      // 3-cycle glitch on port2
      in_port[23:16] = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 2) in_port[23:16] = 8'h00;
         probe(0, 32'hC8, 0, 32'h0, 0, "glitch_pulse");
      end
      for (int k = 0; k < 10; k++) begin
         step(); probe(0, 32'hC8, 0, 32'h0, 0, "glitch_after");
      end
      step(); probe(0, 32'hFC, 0, 32'h0, 0, "glitch_status");

      // 5-cycle hold accepted, then the return to 0 is accepted too
      in_port[23:16] = 8'hFF;
      for (int k = 0; k < 12; k++) begin
         step();
         if (k == 4) in_port[23:16] = 8'h00;
         probe(0, 32'hC8, 0,
               (k >= 6 && k <= 10) ? 32'hFF : 32'h0,
               k >= 6, "hold5");
      end
      step(); probe(0, 32'hFC, 1, 32'h4, 1, "hold5_clr");
      step(); probe(0, 32'hFC, 0, 32'h0, 0, "hold5_after");

      // set-wins: port3 latches on the clearing edge
      in_port[15:8] = 8'h00;
      step(); probe(0, 32'hC4, 0, 32'h3C, 0, "sw_p1_old");
      step(); probe(0, 32'hC4, 0, 32'h3C, 0, "sw_p1_old2");
      in_port[31:24] = 8'h5A;
      for (int k = 0; k < 7; k++) begin
         step();
         if (k < 5)
            probe(0, 32'hCC, 0, 32'h0, k >= 4, "sw_p3_pre");
         else if (k == 5)
            probe(0, 32'hFC, 1, 32'h2, 1, "sw_clr_read");
         else
            probe(0, 32'hFC, 0, 32'h8, 1, "sw_flag3_kept");
      end
      step(); probe(0, 32'hCC, 0, 32'h5A, 1, "sw_p3_val");
      step(); probe(0, 32'hC4, 0, 32'h00, 1, "sw_p1_new");

      // unmapped address and width extension
      step(); probe(0, 32'hD0, 0, 32'h0, 1, "unmapped_d0");
      step(); probe(0, 32'hC0, 0, 32'hA5, 1, "p0_still");
      w_in = 12'hFFF;
      for (int k = 0; k < 7; k++) begin
         step();
         probe(1, 32'hC0, 0, (k == 6) ? 32'hFFF : 32'h0,
               k == 6, "wide_lat");
      end
      step(); probe(1, 32'hFC, 0, 32'h1, 1, "wide_status");
      step(); probe(1, 32'hC4, 0, 32'h0, 1, "wide_unmapped");
      step();
      step();

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/io_input_bank.md
# io_input_bank

Parametrised memory-mapped input-port bank for the I/O space of the single-cycle CPU. Provides NUM_PORTS input ports of PORT_W bits, each with a two-flop synchroniser, a stability debouncer and a sticky change flag. Includes a read-to-clear status register and a level interrupt request. Sits on the CPU's io_read_data path beside the output-port block and decodes addr[7:2] for port selection.

## Interface
- NUM_PORTS, 4: number of input ports, legal range 1..8.
- PORT_W, 8: width of each port, legal range 1..32; port data is zero-extended to 32 bits on read.
- DEB_CYCLES, 4: consecutive stable cycles required before a new value is accepted, legal range 1..255.
- io_clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  CPU byte address; only addr[7:2] is decoded.
- io_rd  in  1  read strobe, one io_clk cycle per CPU load from I/O space.
- in_port  in  NUM_PORTS*PORT_W  raw asynchronous pins; port i occupies bits [i*PORT_W +: PORT_W].
- io_read_data  out  32  combinational read data.
- io_irq  out  1  OR of all change flags.

## Operation
- Address map, decoded on sel = addr[7:2]:
  - port i at sel = 6'b110000 + i;
  - status register at sel = 6'b111111, holding change_flag[NUM_PORTS-1:0] in bits [NUM_PORTS-1:0], upper bits 0;
  - any other sel reads 32'h0. No latches are permitted.
- Per-port pipeline: pins → ff1 → sync → cand → latched.
- Debounce, evaluated per edge:
  - if sync != cand: cand <= sync, cnt <= 0;
  - else if cand != latched: when cnt == DEB_CYCLES-1, latched <= cand, cnt <= 0, change_flag <= 1; otherwise cnt <= cnt+1;
  - else cnt <= 0.
- cnt width is $clog2(DEB_CYCLES+1).
- Multi-bit changes that wander restart the count, so only a value stable for the full window is accepted.
- Port read returns {zeros, latched}. It never returns the raw or sync value.
- Flag clear: io_rd=1 with sel == status clears every change_flag in that cycle. If a port's latched update fires on the same edge, set wins and that flag stays 1.
- Reading a port register does not clear its flag.
- io_irq = |change_flag, registered-source only, no glitching from addr.

## Timing
- Reset (asynchronous assert, synchronous-safe release): ff1, sync, cand, latched, cnt and change_flag are all 0. io_irq = 0. io_read_data = 0 for every address.
- A pin change that meets setup before edge 0 and is held stable gives:
  - ff1 at edge 0;
  - sync at edge 1;
  - cand at edge 2;
  - latched and change_flag at edge 2+DEB_CYCLES.
  - With DEB_CYCLES=4, the new value is visible from edge 6.
- A glitch shorter than DEB_CYCLES+1 cycles at the sync stage is never latched and never sets a flag.
- io_read_data has zero latency: it is a combinational function of addr, latched and change_flag.
- A status read returns the pre-clear value in the io_rd cycle. The flags read 0 from the next cycle unless set-wins applies.
- Reset asserted mid-count aborts the count. After release, a pin that is still changed re-runs the full 2+DEB_CYCLES latency from the first post-reset edge.

## Structure
- Package io_in_pkg holds:
  - IO_IN_PORT_BASE_SEL = 6'b110000;
  - IO_IN_STATUS_SEL = 6'b111111;
  - a function mapping sel to a port index and valid bit.
- Sub-module io_in_channel, parameters PORT_W and DEB_CYCLES:
  - inputs: io_clk, reset, pin, clr;
  - outputs: value, flag;
  - contains ff1, sync, cand, cnt, latched and flag.
- The top generates NUM_PORTS channels and contains the read mux and the io_irq OR.

## Test plan
- Reset mid-operation, defaults: drive in_port0 = 8'hA5 and assert reset before edge 6 → latched stays 0 and io_irq = 0. After release, port0 reads 32'h000000A5 exactly 6 edges later.
- Stable change: port1 from 8'h00 to 8'h3C at edge 0 → addr 32'hC4 reads 32'h3C from edge 6 and not before. Status reads 32'h2. io_irq = 1.
- Glitch rejection: port2 pulses to 8'hFF for 3 cycles → port2 reads 0, status stays 0 and io_irq stays 0. A 5-cycle hold is accepted.
- Read-to-clear and set-wins: status read with io_rd=1 returns 32'h2, then reads 32'h0. In a second case a port3 latch fires on the same edge as the clear → flag3 remains 1.
- Unmapped address and width extension: addr 32'hD0 (sel = 6'b110100, NUM_PORTS = 4) reads 32'h0. With PORT_W = 12, a port driven to 12'hFFF reads 32'h00000FFF.
